tick_timer: RTL and testbench

Programmable down-count timer directly downstream of the 3-state cyclic tick generator; consumes its one-in-three-cycles strobe as tick_i.
Counts a software-loaded number of ticks, then emits a single-cycle done pulse.
Lets the control unit build longer, programmable delays from the fixed-rate tick.
Start/stop/restart controls, busy status and a sticky restart-overrun flag are included.

---
 rtl/tick_timer.sv | 112 +++++++++++
 tb/tb_tick_timer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer.sv
// tick_timer: programmable down-count timer driven by an upstream tick strobe.
// Counts load_val_i ticks, then pulses done_o for one cycle.
//
// Ports:
//   clk         system clock, rising-edge
//   reset       asynchronous, active-high
//   tick_i      tick strobe from the upstream generator (one cycle in three)
//   start_i     load load_val_i and begin counting (restarts when running)
//   stop_i      abort and return to IDLE; highest priority
//   load_val_i  number of ticks to count; sampled only on an accepted start
//   count_o     remaining ticks (the counter register itself)
//   busy_o      high while counting (RUN)
//   done_o      one-cycle completion pulse (DONE)
//   overrun_o   sticky; set when a start arrives while already counting
module tick_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overrun_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] count;
    logic             overrun;

    // A zero load skips RUN entirely so a zero-length timer still pulses.
    logic   load_zero;
    state_t load_next;

    // Counting ends on the tick that takes the counter from 1 to 0.
    // Treating 0 as final too keeps the counter from ever wrapping.
    logic last_tick;

    assign load_zero = (load_val_i == '0);
    assign load_next = load_zero ? DONE : RUN;
    assign last_tick = (count <= WIDTH'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (stop_i) begin
                        state <= IDLE;
                    end else if (start_i) begin
                        count <= load_val_i;
                        state <= load_next;
                    end
                end

                RUN: begin
                    if (stop_i) begin
                        // Counter is left frozen so software can see
                        // how far the aborted timer got.
                        state <= IDLE;
                    end else if (start_i) begin
                        // Restart wins over a coincident tick.
                        count   <= load_val_i;
                        overrun <= 1'b1;
                        state   <= load_next;
                    end else if (tick_i) begin
                        if (last_tick) begin
                            count <= '0;
                            state <= DONE;
                        end else begin
                            count <= count - WIDTH'(1);
                        end
                    end
                end

                DONE: begin
                    if (stop_i) begin
                        state <= IDLE;
                    end else if (start_i) begin
                        // Back-to-back timers with no idle gap.
                        count <= load_val_i;
                        state <= load_next;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign count_o   = count;
    assign busy_o    = (state == RUN);
    assign done_o    = (state == DONE);
    assign overrun_o = overrun;

endmodule

// File: tb/tb_tick_timer.sv
// tb_tick_timer: directed vector table, reset corner cases and a randomized
// run against a behavioural model of the timer.
module tb_tick_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_i;
    logic       start_i;
    logic       stop_i;
    logic [7:0] load_val_i;
    logic [7:0] count_o;
    logic       busy_o;
    logic       done_o;
    logic       overrun_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    tick_timer #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_i     (tick_i),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .load_val_i (load_val_i),
        .count_o    (count_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .overrun_o  (overrun_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       stop;
        logic       start;
        logic       tick;
        logic [7:0] load;
        logic [7:0] e_count;
        logic       e_busy;
        logic       e_done;
        logic       e_ov;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] c,
                         input logic b, input logic d, input logic o);
        total_cnt++;
        if (count_o === c && busy_o === b && done_o === d &&
            overrun_o === o && !(busy_o && done_o)) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got count=%0d busy=%b done=%b ov=%b, want count=%0d busy=%b done=%b ov=%b",
                     name, count_o, busy_o, done_o, overrun_o, c, b, d, o);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; outputs settle after
    // the following rising edge.
    task automatic step(input logic sp, input logic st, input logic tk,
                        input logic [7:0] ld);
        @(negedge clk);
        stop_i     = sp;
        start_i    = st;
        tick_i     = tk;
        load_val_i = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic sp, input logic st, input logic tk,
                       input logic [7:0] ld, input logic [7:0] c,
                       input logic b, input logic d, input logic o);
        vec_t v;
        v.stop = sp; v.start = st; v.tick = tk; v.load = ld;
        v.e_count = c; v.e_busy = b; v.e_done = d; v.e_ov = o;
        vecs.push_back(v);
    endtask

    // Behavioural model: ticks remaining, whether counting, pulse flag.
    int   m_left;
    bit   m_counting;
    bit   m_pulse;
    bit   m_ov;

    task automatic model_step(input bit sp, input bit st, input bit tk,
                              input int ld);
        m_pulse = 0;
        if (sp) begin
            m_counting = 0;
        end else if (st) begin
            if (m_counting) m_ov = 1;
            m_left     = ld;
            m_counting = (ld != 0);
            m_pulse    = (ld == 0);
        end else if (m_counting && tk) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_counting = 0;
                m_pulse    = 1;
            end
        end
    endtask

    initial begin
        reset = 1'b1; tick_i = 0; start_i = 0; stop_i = 0; load_val_i = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 8'd0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // basic count of 4 with period-3 ticks
        add(0,1,0,8'd4,   8'd4,1,0,0);
        add(0,0,1,8'd0,   8'd3,1,0,0);
        add(0,0,0,8'd0,   8'd3,1,0,0);
        add(0,0,0,8'd0,   8'd3,1,0,0);
        add(0,0,1,8'd0,   8'd2,1,0,0);
        add(0,0,0,8'd0,   8'd2,1,0,0);
        add(0,0,0,8'd0,   8'd2,1,0,0);
        add(0,0,1,8'd0,   8'd1,1,0,0);
        add(0,0,0,8'd0,   8'd1,1,0,0);
        add(0,0,0,8'd0,   8'd1,1,0,0);
        add(0,0,1,8'd0,   8'd0,0,1,0);
        add(0,0,0,8'd0,   8'd0,0,0,0);
        add(0,0,1,8'd0,   8'd0,0,0,0);
        // zero load
        add(0,1,0,8'd0,   8'd0,0,1,0);
        add(0,0,0,8'd0,   8'd0,0,0,0);
        // stop mid-count, count frozen
        add(0,1,0,8'd6,   8'd6,1,0,0);
        add(0,0,1,8'd0,   8'd5,1,0,0);
        add(0,0,1,8'd0,   8'd4,1,0,0);
        add(1,0,0,8'd0,   8'd4,0,0,0);
        add(0,0,1,8'd0,   8'd4,0,0,0);
        // back-to-back start in DONE, then stop+start together
        add(0,1,0,8'd1,   8'd1,1,0,0);
        add(0,0,1,8'd0,   8'd0,0,1,0);
        add(0,1,0,8'd2,   8'd2,1,0,0);
        add(1,1,0,8'd7,   8'd2,0,0,0);
        // restart overrun, coincident tick ignored
        add(0,1,0,8'd5,   8'd5,1,0,0);
        add(0,0,1,8'd0,   8'd4,1,0,0);
        add(0,1,1,8'd3,   8'd3,1,0,1);
        add(0,0,1,8'd0,   8'd2,1,0,1);
        add(0,0,1,8'd0,   8'd1,1,0,1);
        add(0,0,1,8'd0,   8'd0,0,1,1);
        add(0,0,0,8'd0,   8'd0,0,0,1);
        // restart with zero load while running, stop in DONE
        add(0,1,0,8'd2,   8'd2,1,0,1);
        add(0,1,0,8'd0,   8'd0,0,1,1);
        add(1,1,0,8'd9,   8'd0,0,0,1);
        // maximum load
        add(0,1,0,8'd255, 8'd255,1,0,1);
        add(0,0,1,8'd0,   8'd254,1,0,1);
        add(1,0,1,8'd0,   8'd254,0,0,1);

        foreach (vecs[i]) begin
            step(vecs[i].stop, vecs[i].start, vecs[i].tick, vecs[i].load);
            check($sformatf("vec%0d", i), vecs[i].e_count,
                  vecs[i].e_busy, vecs[i].e_done, vecs[i].e_ov);
        end

        // reset mid-count takes effect without a clock edge
        step(0,1,0,8'd5);
        step(0,0,1,8'd0);
        step(0,0,1,8'd0);
        check("pre_reset", 8'd3, 1, 0, 1);
        @(negedge clk);
        stop_i = 0; start_i = 0; tick_i = 0;
        #2 reset = 1'b1;
        #1;
        check("async_reset", 8'd0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        step(0,0,1,8'd0);
        step(0,0,1,8'd0);
        check("post_reset_idle", 8'd0, 0, 0, 0);

        // randomized run against the model
        m_left = 0; m_counting = 0; m_pulse = 0; m_ov = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit sp, st, tk;
            int ld;
            tk = ((cyc % 3) == 0) ^ ($urandom_range(0, 19) == 0);
            st = ($urandom_range(0, 11) == 0);
            sp = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 9))
                0:       ld = 0;
                1:       ld = 255;
                default: ld = $urandom_range(1, 6);
            endcase
            step(sp, st, tk, 8'(ld));
            model_step(sp, st, tk, ld);
            check($sformatf("rand%0d", cyc), 8'(m_left),
                  m_counting, m_pulse, m_ov);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
